// File: rtl/arb8way16_pkg.sv
// Shared constants and the occupancy state type for the 8-way, 16-bit round-robin arbiter.
package arb8way16_pkg;
    localparam int NWAY  = 8;
    localparam int WIDTH = 16;
    localparam int SELW  = 3;

    localparam logic [SELW-1:0] LAST_RST = 3'd7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/arb8way16_if.sv
// Requester/consumer bus of arb8way16. The lock vector exists only when ARB8WAY16_LOCK_EN is defined.
interface arb8way16_if;
    import arb8way16_pkg::*;

    logic [NWAY-1:0]  req;
    logic [WIDTH-1:0] i0, i1, i2, i3, i4, i5, i6, i7;
    logic [NWAY-1:0]  ack;
    logic [WIDTH-1:0] out;
    logic [SELW-1:0]  out_sel;
    logic             out_valid;
    logic             out_ready;
`ifdef ARB8WAY16_LOCK_EN
    logic [NWAY-1:0]  lock;

    modport master (output req, i0, i1, i2, i3, i4, i5, i6, i7, out_ready, lock,
                    input  ack, out, out_sel, out_valid);
    modport slave  (input  req, i0, i1, i2, i3, i4, i5, i6, i7, out_ready, lock,
                    output ack, out, out_sel, out_valid);
`else
    modport master (output req, i0, i1, i2, i3, i4, i5, i6, i7, out_ready,
                    input  ack, out, out_sel, out_valid);
    modport slave  (input  req, i0, i1, i2, i3, i4, i5, i6, i7, out_ready,
                    output ack, out, out_sel, out_valid);
`endif
endinterface

// File: rtl/mux8way16.sv
// Eight-way, 16-bit combinational word multiplexer.
module mux8way16
    import arb8way16_pkg::*;
(
    input  logic [WIDTH-1:0] i0, i1, i2, i3, i4, i5, i6, i7,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (sel)
            3'd0:    y = i0;
            3'd1:    y = i1;
            3'd2:    y = i2;
            3'd3:    y = i3;
            3'd4:    y = i4;
            3'd5:    y = i5;
            3'd6:    y = i6;
            default: y = i7;
        endcase
    end
endmodule

// File: rtl/arb8way16.sv
// Round-robin arbiter over eight 16-bit requesters feeding a one-deep valid/ready output register.
// Define ARB8WAY16_LOCK_EN to add the lock input, which lets the previous winner hold the grant.
module arb8way16
    import arb8way16_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    arb8way16_if.slave bus
);
    state_t           state, state_nxt;
    logic [SELW-1:0]  last, win, idx;
    logic [WIDTH-1:0] mux_y;
    logic             space, capture;

    assign space   = (state == ST_EMPTY) || bus.out_ready;
    assign capture = space && (|bus.req);

    // Scan from the farthest offset down so the nearest requester after `last` wins.
    always_comb begin
        win = last;
        idx = last;
        for (int k = NWAY; k >= 1; k--) begin
            idx = last + SELW'(k);
            if (bus.req[idx]) win = idx;
        end
`ifdef ARB8WAY16_LOCK_EN
        if (bus.lock[last] && bus.req[last]) win = last;
`endif
    end

    always_comb begin
        bus.ack = '0;
        if (capture && !reset) bus.ack[win] = 1'b1;
    end

    mux8way16 u_mux (
        .i0 (bus.i0), .i1 (bus.i1), .i2 (bus.i2), .i3 (bus.i3),
        .i4 (bus.i4), .i5 (bus.i5), .i6 (bus.i6), .i7 (bus.i7),
        .sel(win),
        .y  (mux_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            last        <= LAST_RST;
            bus.out     <= '0;
            bus.out_sel <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                bus.out     <= mux_y;
                bus.out_sel <= win;
                last        <= win;
            end
        end
    end

    // A capture while full is a simultaneous drain and refill, so FULL is kept.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (capture) state_nxt = ST_FULL;
            ST_FULL:  if (!capture && bus.out_ready) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == ST_FULL);
    end
endmodule

// File: tb/tb_arb8way16.sv
// Directed self-checking bench for arb8way16 (lock scenario built only with ARB8WAY16_LOCK_EN).
module tb_arb8way16;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] data [8];

    arb8way16_if bus();

    arb8way16 dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
`ifdef ARB8WAY16_LOCK_EN
        bus.lock = 8'h00;
`endif
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 8'hFF;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.ack !== 8'h00) begin errors++; $display("FAIL reset_ack got=%h exp=00", bus.ack); end
        step();
        bus.req = 8'h00;
        step();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.ack !== 8'h00) begin errors++; $display("FAIL idle_ack c%0d got=%h exp=00", c, bus.ack); end
            step();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid c%0d got=%b exp=0", c, bus.out_valid); end
            checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL idle_out c%0d got=%h exp=0000", c, bus.out); end
            checks++; if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL idle_sel c%0d got=%0d exp=0", c, bus.out_sel); end
        end
    endtask

    task automatic test_single();
        bus.req = 8'h01;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.ack !== 8'h01) begin errors++; $display("FAIL single_ack got=%h exp=01", bus.ack); end
        step();
        bus.req = 8'h00;
        #1;
        checks++; if (bus.out !== 16'hAAAA) begin errors++; $display("FAIL single_out got=%h exp=AAAA", bus.out); end
        checks++; if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL single_sel got=%0d exp=0", bus.out_sel); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.ack !== 8'h00) begin errors++; $display("FAIL single_ack_idle got=%h exp=00", bus.ack); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out !== 16'hAAAA) begin errors++; $display("FAIL single_hold got=%h exp=AAAA", bus.out); end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_ack;
        int e;
        do_reset();
        bus.req = 8'hFF;
        bus.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) begin
            e = k % 8;
            exp_ack = 8'h01 << e;
            checks++; if (bus.ack !== exp_ack) begin errors++; $display("FAIL rr_ack k%0d got=%h exp=%h", k, bus.ack, exp_ack); end
            step();
            checks++; if (bus.out_sel !== 3'(e)) begin errors++; $display("FAIL rr_sel k%0d got=%0d exp=%0d", k, bus.out_sel, e); end
            checks++; if (bus.out !== data[e]) begin errors++; $display("FAIL rr_out k%0d got=%h exp=%h", k, bus.out, data[e]); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid k%0d got=%b exp=1", k, bus.out_valid); end
        end
        bus.req = 8'h00;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req = 8'h0C;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.ack !== 8'h04) begin errors++; $display("FAIL bp_first_ack got=%h exp=04", bus.ack); end
        step();
        bus.out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.ack !== 8'h00) begin errors++; $display("FAIL bp_stall_ack c%0d got=%h exp=00", c, bus.ack); end
            step();
            checks++; if (bus.out !== 16'hCCCC) begin errors++; $display("FAIL bp_stall_out c%0d got=%h exp=CCCC", c, bus.out); end
            checks++; if (bus.out_sel !== 3'd2) begin errors++; $display("FAIL bp_stall_sel c%0d got=%0d exp=2", c, bus.out_sel); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid c%0d got=%b exp=1", c, bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.ack !== 8'h08) begin errors++; $display("FAIL bp_release_ack got=%h exp=08", bus.ack); end
        step();
        checks++; if (bus.out !== 16'hDDDD) begin errors++; $display("FAIL bp_next_out got=%h exp=DDDD", bus.out); end
        checks++; if (bus.out_sel !== 3'd3) begin errors++; $display("FAIL bp_next_sel got=%0d exp=3", bus.out_sel); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble got=%b exp=1", bus.out_valid); end
        bus.req = 8'h00;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_midstream_reset();
        bus.req = 8'h30;
        bus.out_ready = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mr_pre_valid got=%b exp=1", bus.out_valid); end
        reset = 1'b1;
        bus.req = 8'hFF;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.ack !== 8'h00) begin errors++; $display("FAIL mr_ack_in_reset got=%h exp=00", bus.ack); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL mr_out got=%h exp=0000", bus.out); end
        checks++; if (bus.ack !== 8'h01) begin errors++; $display("FAIL mr_first_ack got=%h exp=01", bus.ack); end
        step();
        checks++; if (bus.out !== 16'hAAAA) begin errors++; $display("FAIL mr_first_out got=%h exp=AAAA", bus.out); end
        checks++; if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL mr_first_sel got=%0d exp=0", bus.out_sel); end
        bus.req = 8'h00;
        step();
    endtask

`ifdef ARB8WAY16_LOCK_EN
    task automatic test_lock();
        int e;
        do_reset();
        bus.req = 8'h20;
        bus.out_ready = 1'b1;
        step();
        bus.req = 8'hFF;
        bus.lock = 8'h20;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.ack !== 8'h20) begin errors++; $display("FAIL lock_ack c%0d got=%h exp=20", c, bus.ack); end
            step();
            checks++; if (bus.out !== 16'h0010) begin errors++; $display("FAIL lock_out c%0d got=%h exp=0010", c, bus.out); end
        end
        bus.lock = 8'h00;
        #1;
        for (int c = 0; c < 3; c++) begin
            e = (6 + c) % 8;
            step();
            checks++; if (bus.out_sel !== 3'(e)) begin errors++; $display("FAIL unlock_sel c%0d got=%0d exp=%0d", c, bus.out_sel, e); end
            checks++; if (bus.out !== data[e]) begin errors++; $display("FAIL unlock_out c%0d got=%h exp=%h", c, bus.out, data[e]); end
        end
        bus.req = 8'h00;
        step();
    endtask
`endif

    initial begin
        data[0] = 16'hAAAA; data[1] = 16'hBBBB; data[2] = 16'hCCCC; data[3] = 16'hDDDD;
        data[4] = 16'h0001; data[5] = 16'h0010; data[6] = 16'h0100; data[7] = 16'h1000;
        bus.i0 = data[0]; bus.i1 = data[1]; bus.i2 = data[2]; bus.i3 = data[3];
        bus.i4 = data[4]; bus.i5 = data[5]; bus.i6 = data[6]; bus.i7 = data[7];
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
`ifdef ARB8WAY16_LOCK_EN
        bus.lock = 8'h00;
`endif
        reset = 1'b1;
        #1;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_midstream_reset();
`ifdef ARB8WAY16_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
